// File: rtl/frame_pkg.sv
// Shared types and default sizes for the frame receive path.
package frame_pkg;

    typedef enum logic [1:0] {
        PRE_B = 2'd0,
        PRE_M = 2'd1,
        PRE_W = 2'd2
    } preamble_t;

    typedef enum logic [1:0] {
        HUNT,
        RUN,
        ERR
    } seq_state_t;

    localparam int SUBFRAME_BITS_DEF    = 28;
    localparam int FRAMES_PER_BLOCK_DEF = 192;

endpackage

// File: rtl/frame_sequencer_sat_counter.sv
// Saturating up-counter used for the sequencer statistics.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (inc_i && !(&count_q)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/frame_sequencer.sv
// Receive sequencer feeding frame_dismantle: preamble order, subframe length, timeout.
// Statistics counters are built only when FRAME_SEQ_STATS_EN is defined.
//
// state | meaning
// HUNT  | waiting for a B preamble, bits ignored
// RUN   | forwarding payload bits, checking framing
// ERR   | one-cycle fault: sync_err + dis_rst, then HUNT
module frame_sequencer
    import frame_pkg::*;
#(
    parameter int SUBFRAME_BITS    = SUBFRAME_BITS_DEF,
    parameter int FRAMES_PER_BLOCK = FRAMES_PER_BLOCK_DEF,
    parameter int TIMEOUT          = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bit_valid,
    input  logic        bit_data,
    input  logic        pre_valid,
    input  logic [1:0]  pre_type,
    input  logic        done,
    input  logic        kill,
    output logic        vin,
    output logic        din,
    output logic [7:0]  frame_counter,
    output logic        in_channel,
    output logic        dis_rst,
    output logic        locked,
    output logic        sync_err,
    output logic [15:0] block_count,
    output logic [7:0]  err_count
);

    localparam int BW = $clog2(SUBFRAME_BITS + 1);
    localparam int IW = $clog2(TIMEOUT + 1);

    seq_state_t     state_q, state_d;
    logic [BW-1:0]  bit_cnt_q, bit_cnt_d;
    logic [IW-1:0]  idle_q, idle_d;
    logic [7:0]     frame_q, frame_d;
    logic           chan_q, chan_d;
    logic           vin_q, vin_d;
    logic           din_q, din_d;
    logic           locked_q, locked_d;
    logic           fault;
    logic           full;
    preamble_t      exp_pre;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= HUNT;
            bit_cnt_q <= '0;
            idle_q    <= '0;
            frame_q   <= '0;
            chan_q    <= 1'b0;
            vin_q     <= 1'b0;
            din_q     <= 1'b0;
            locked_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            idle_q    <= idle_d;
            frame_q   <= frame_d;
            chan_q    <= chan_d;
            vin_q     <= vin_d;
            din_q     <= din_d;
            locked_q  <= locked_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        idle_d    = idle_q;
        frame_d   = frame_q;
        chan_d    = chan_q;
        vin_d     = 1'b0;
        din_d     = din_q;
        locked_d  = locked_q;
        fault     = 1'b0;
        full      = (bit_cnt_q == BW'(SUBFRAME_BITS));
        // Channel A is always followed by W; channel B by M, or B at block end
        if (!chan_q) begin
            exp_pre = PRE_W;
        end else if (frame_q == 8'(FRAMES_PER_BLOCK - 1)) begin
            exp_pre = PRE_B;
        end else begin
            exp_pre = PRE_M;
        end

        case (state_q)
            HUNT: begin
                if (pre_valid && pre_type == PRE_B) begin
                    state_d   = RUN;
                    bit_cnt_d = '0;
                    idle_d    = '0;
                    frame_d   = '0;
                    chan_d    = 1'b0;
                end
            end
            RUN: begin
                if (bit_valid && pre_valid) begin
                    fault = 1'b1;
                end else if (pre_valid) begin
                    if (!full || pre_type != exp_pre) begin
                        fault = 1'b1;
                    end else begin
                        bit_cnt_d = '0;
                        if (!chan_q) begin
                            chan_d = 1'b1;
                        end else begin
                            chan_d  = 1'b0;
                            frame_d = (exp_pre == PRE_B) ? 8'd0 : frame_q + 8'd1;
                        end
                    end
                end else if (bit_valid) begin
                    if (full) begin
                        fault = 1'b1;
                    end else begin
                        vin_d     = 1'b1;
                        din_d     = bit_data;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end

                if (kill) begin
                    fault = 1'b1;
                end

                if (bit_valid || pre_valid) begin
                    idle_d = '0;
                end else if (idle_q == IW'(TIMEOUT - 1)) begin
                    fault = 1'b1;
                end else begin
                    idle_d = idle_q + 1'b1;
                end

                if (done && !kill) begin
                    locked_d = 1'b1;
                end

                if (fault) begin
                    state_d  = ERR;
                    vin_d    = 1'b0;
                    locked_d = 1'b0;
                end
            end
            ERR: begin
                state_d   = HUNT;
                bit_cnt_d = '0;
                idle_d    = '0;
                locked_d  = 1'b0;
            end
            default: begin
                state_d = HUNT;
            end
        endcase
    end

    assign vin           = vin_q;
    assign din           = din_q;
    assign frame_counter = frame_q;
    assign in_channel    = chan_q;
    assign locked        = locked_q;
    assign sync_err      = (state_q == ERR);
    assign dis_rst       = (state_q == ERR);

`ifdef FRAME_SEQ_STATS_EN
    logic good_blk;
    assign good_blk = (state_q == RUN) && done && !kill;

    sat_counter #(.WIDTH(16)) u_block_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (good_blk),
        .count_o (block_count)
    );

    sat_counter #(.WIDTH(8)) u_err_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (state_q == ERR),
        .count_o (err_count)
    );
`else
    assign block_count = '0;
    assign err_count   = '0;
`endif

endmodule
